id_regfile_fwd: RTL and testbench

//  ID-stage register file and operand bypass for the 5-stage MIPS pipeline.
//  - Receives the writeback bus and commits it to a 32x32 GPR array.
//  - Resolves RAW hazards by forwarding from the EX, MEM and WB buses.
//  - Detects load-use hazards and raises a stall request to the stall controller.

---
 rtl/id_regfile_fwd_pkg.sv | 20 ++
 rtl/id_regfile_fwd_regfile_array.sv | 35 +++
 rtl/id_regfile_fwd.sv | 90 +++++++++
 tb/tb_id_regfile_fwd.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/id_regfile_fwd_pkg.sv
// Shared constants for the ID-stage register file: geometry, bus layouts, stall encoding.
// Bus fields pack as {[is_load,] we, waddr, wdata}, with wdata in the LSBs.
package id_regfile_fwd_pkg;

    localparam int NREG_DEF = 32;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;

    localparam int EX_TO_ID_WD  = 39;
    localparam int MEM_TO_ID_WD = 38;
    localparam int WB_TO_RF_WD  = 38;

    localparam int WADDR_LSB = DW_DEF;
    localparam int WE_BIT    = DW_DEF + AW_DEF;
    localparam int LD_BIT    = DW_DEF + AW_DEF + 1;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/id_regfile_fwd_regfile_array.sv
// Plain GPR storage: one write port, two combinational read ports, no bypass.
// Synchronous reset clears every entry and takes priority over a same-cycle write.
module regfile_array #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem [NREG];

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/id_regfile_fwd.sv
// ID-stage GPR file with EX/MEM/WB operand bypass; reads are 0-cycle combinational.
// Raises stallreq_ld when an EX-stage load targets a register this instruction reads.
module id_regfile_fwd
    import id_regfile_fwd_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    input  logic             re2,
    input  logic [AW-1:0]    raddr2,
    input  logic [DW+AW+1:0] ex_to_id_bus,
    input  logic [DW+AW:0]   mem_to_id_bus,
    input  logic [DW+AW:0]   wb_to_rf_bus,
    output logic [DW-1:0]    rdata1,
    output logic [DW-1:0]    rdata2,
    output logic             stallreq_ld
);

    logic          ex_ld, ex_we, mem_we, wb_we;
    logic [AW-1:0] ex_wa, mem_wa, wb_wa;
    logic [DW-1:0] ex_wd, mem_wd, wb_wd;
    logic [DW-1:0] arr_rd1, arr_rd2;

    assign ex_ld  = ex_to_id_bus[DW+AW+1];
    assign ex_we  = ex_to_id_bus[DW+AW];
    assign ex_wa  = ex_to_id_bus[DW+AW-1:DW];
    assign ex_wd  = ex_to_id_bus[DW-1:0];
    assign mem_we = mem_to_id_bus[DW+AW];
    assign mem_wa = mem_to_id_bus[DW+AW-1:DW];
    assign mem_wd = mem_to_id_bus[DW-1:0];
    assign wb_we  = wb_to_rf_bus[DW+AW];
    assign wb_wa  = wb_to_rf_bus[DW+AW-1:DW];
    assign wb_wd  = wb_to_rf_bus[DW-1:0];

    regfile_array #(
        .NREG (NREG),
        .DW   (DW),
        .AW   (AW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_wa),
        .wdata  (wb_wd),
        .raddr1 (raddr1),
        .rdata1 (arr_rd1),
        .raddr2 (raddr2),
        .rdata2 (arr_rd2)
    );

    // One resolver per read port; youngest producer (EX) wins, WB gives write-through.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] arr;
        logic [DW-1:0] res;
        logic          ld_hit;

        assign re   = (p == 0) ? re1     : re2;
        assign addr = (p == 0) ? raddr1  : raddr2;
        assign arr  = (p == 0) ? arr_rd1 : arr_rd2;

        always_comb begin
            res    = arr;
            ld_hit = 1'b0;
            if (!re || addr == '0) begin
                res = '0;
            end else begin
                ld_hit = ex_ld && ex_we && (ex_wa == addr);
                if (ex_we && ex_wa == addr) begin
                    res = ex_wd;
                end else if (mem_we && mem_wa == addr) begin
                    res = mem_wd;
                end else if (wb_we && wb_wa == addr) begin
                    res = wb_wd;
                end
            end
        end
    end

    assign rdata1      = rst ? '0 : g_port[0].res;
    assign rdata2      = rst ? '0 : g_port[1].res;
    assign stallreq_ld = (!rst && (g_port[0].ld_hit || g_port[1].ld_hit)) ? STOP : NO_STOP;

endmodule

// File: tb/tb_id_regfile_fwd.sv
// Directed table, hand sequences and randomized traffic against an array-based reference model.
module tb_id_regfile_fwd;
    import id_regfile_fwd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic        ex_ld, ex_we, mem_we, wb_we;
    logic [4:0]  ex_wa, mem_wa, wb_wa;
    logic [31:0] ex_wd, mem_wd, wb_wd;
    logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
    logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus;
    logic [31:0] rdata1, rdata2;
    logic        stallreq_ld;

    assign ex_to_id_bus  = {ex_ld, ex_we, ex_wa, ex_wd};
    assign mem_to_id_bus = {mem_we, mem_wa, mem_wd};
    assign wb_to_rf_bus  = {wb_we, wb_wa, wb_wd};

    always #5 clk = ~clk;

    id_regfile_fwd dut (
        .clk           (clk),
        .rst           (rst),
        .re1           (re1),
        .raddr1        (raddr1),
        .re2           (re2),
        .raddr2        (raddr2),
        .ex_to_id_bus  (ex_to_id_bus),
        .mem_to_id_bus (mem_to_id_bus),
        .wb_to_rf_bus  (wb_to_rf_bus),
        .rdata1        (rdata1),
        .rdata2        (rdata2),
        .stallreq_ld   (stallreq_ld)
    );

    int total = 0;
    int bad   = 0;

    // Reference register state: an architectural view of the GPRs.
    logic [31:0] gpr [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (rst) return 32'h0;
        if (!re || a == 5'd0) return 32'h0;
        if (ex_we && ex_wa == a) return ex_wd;
        if (mem_we && mem_wa == a) return mem_wd;
        if (wb_we && wb_wa == a) return wb_wd;
        return gpr[a];
    endfunction

    function automatic logic model_stall();
        if (rst) return NO_STOP;
        if (!(ex_ld && ex_we && ex_wa != 5'd0)) return NO_STOP;
        if ((re1 && raddr1 == ex_wa) || (re2 && raddr2 == ex_wa)) return STOP;
        return NO_STOP;
    endfunction

    // Advance one clock, committing the current inputs to the model alongside the DUT.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
        end else if (wb_we && wb_wa != 5'd0) begin
            gpr[wb_wa] = wb_wd;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
        ex_ld = 1'b0; ex_we = 1'b0; ex_wa = '0; ex_wd = '0;
        mem_we = 1'b0; mem_wa = '0; mem_wd = '0;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    endtask

    typedef struct {
        logic        re1;  logic [4:0] a1;
        logic        re2;  logic [4:0] a2;
        logic        exl;  logic ewe; logic [4:0] ewa; logic [31:0] ewd;
        logic        mwe;  logic [4:0] mwa; logic [31:0] mwd;
        logic        wwe;  logic [4:0] wwa; logic [31:0] wwd;
        logic [31:0] e1;   logic [31:0] e2;
        logic        c2;   // port-2 data checked (ignored while stalled)
        logic        es;
    } vec_t;

    vec_t vt [14];

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Outputs forced quiet during reset even with an EX load hitting port 1.
        re1 = 1'b1; raddr1 = 5'd4; ex_ld = 1'b1; ex_we = 1'b1; ex_wa = 5'd4; ex_wd = 32'h1;
        step();
        #1;
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rdata2", rdata2, 32'h0);
        check("rst_stall", {31'h0, stallreq_ld}, {31'h0, NO_STOP});
        step();
        idle_inputs();
        #1;

        for (int r = 1; r < 32; r++) begin
            re1 = 1'b1; raddr1 = 5'(r); re2 = 1'b1; raddr2 = 5'(32 - r);
            #1;
            check($sformatf("post_rst_r%0d_p1", r), rdata1, 32'h0);
            check($sformatf("post_rst_r%0d_p2", r), rdata2, 32'h0);
            check("post_rst_stall", {31'h0, stallreq_ld}, {31'h0, NO_STOP});
        end

        //        re1 a1    re2 a2    exl ewe ewa   ewd           mwe mwa   mwd           wwe wwa   wwd           e1            e2            c2 es
        vt[0]  = '{1, 5'd5, 1, 5'd0,  0,  0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        1,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1, 0};
        vt[1]  = '{1, 5'd5, 1, 5'd0,  0,  0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        1,  5'd0, 32'h1,        32'hDEADBEEF, 32'h0,        1, 0};
        vt[2]  = '{1, 5'd0, 1, 5'd5,  0,  0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0};
        vt[3]  = '{0, 5'd7, 1, 5'd7,  0,  0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        1,  5'd7, 32'h11,       32'h0,        32'h11,       1, 0};
        vt[4]  = '{1, 5'd3, 1, 5'd3,  0,  1,  5'd3, 32'hA,        1,  5'd3, 32'hB,        1,  5'd3, 32'hC,        32'hA,        32'hA,        1, 0};
        vt[5]  = '{1, 5'd3, 1, 5'd7,  0,  0,  5'd3, 32'hA,        1,  5'd3, 32'hB,        1,  5'd3, 32'hC,        32'hB,        32'h11,       1, 0};
        vt[6]  = '{1, 5'd3, 0, 5'd3,  0,  0,  5'd3, 32'hA,        0,  5'd3, 32'hB,        1,  5'd3, 32'hC,        32'hC,        32'h0,        1, 0};
        vt[7]  = '{1, 5'd3, 1, 5'd5,  0,  0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        32'hC,        32'hDEADBEEF, 1, 0};
        vt[8]  = '{1, 5'd5, 1, 5'd8,  1,  1,  5'd8, 32'h99,       0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        0, 1};
        vt[9]  = '{1, 5'd5, 0, 5'd8,  1,  1,  5'd8, 32'h99,       0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        1, 0};
        vt[10] = '{0, 5'd0, 1, 5'd8,  0,  0,  5'd0, 32'h0,        1,  5'd8, 32'h55,       0,  5'd0, 32'h0,        32'h0,        32'h55,       1, 0};
        vt[11] = '{1, 5'd8, 1, 5'd8,  1,  0,  5'd8, 32'h77,       0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        32'h0,        32'h0,        1, 0};
        vt[12] = '{1, 5'd0, 1, 5'd0,  1,  1,  5'd0, 32'h7,        1,  5'd0, 32'h8,        1,  5'd0, 32'h9,        32'h0,        32'h0,        1, 0};
        vt[13] = '{1, 5'd9, 1, 5'd3,  1,  1,  5'd9, 32'h42,       0,  5'd0, 32'h0,        0,  5'd0, 32'h0,        32'h42,       32'hC,        1, 1};

        for (int i = 0; i < 14; i++) begin
            re1 = vt[i].re1; raddr1 = vt[i].a1; re2 = vt[i].re2; raddr2 = vt[i].a2;
            ex_ld = vt[i].exl; ex_we = vt[i].ewe; ex_wa = vt[i].ewa; ex_wd = vt[i].ewd;
            mem_we = vt[i].mwe; mem_wa = vt[i].mwa; mem_wd = vt[i].mwd;
            wb_we = vt[i].wwe; wb_wa = vt[i].wwa; wb_wd = vt[i].wwd;
            #1;
            check($sformatf("vec%0d_rdata1", i), rdata1, vt[i].e1);
            if (vt[i].c2) check($sformatf("vec%0d_rdata2", i), rdata2, vt[i].e2);
            check($sformatf("vec%0d_stall", i), {31'h0, stallreq_ld}, {31'h0, vt[i].es});
            step();
        end

        // Reset mid-stream wipes committed data and swallows a same-cycle WB write.
        idle_inputs();
        wb_we = 1'b1; wb_wa = 5'd9; wb_wd = 32'h1234;
        step();
        wb_we = 1'b0; re1 = 1'b1; raddr1 = 5'd9;
        #1;
        check("seq_r9_written", rdata1, 32'h1234);
        rst = 1'b1; wb_we = 1'b1; wb_wa = 5'd10; wb_wd = 32'h77;
        ex_ld = 1'b1; ex_we = 1'b1; ex_wa = 5'd9;
        #1;
        check("seq_rst_rdata1", rdata1, 32'h0);
        check("seq_rst_stall", {31'h0, stallreq_ld}, {31'h0, NO_STOP});
        step();
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd10;
        #1;
        check("seq_r9_cleared", rdata1, 32'h0);
        check("seq_r10_lost", rdata2, 32'h0);
        raddr1 = 5'd5; raddr2 = 5'd3;
        #1;
        check("seq_r5_cleared", rdata1, 32'h0);
        check("seq_r3_cleared", rdata2, 32'h0);
        step();

        // Randomized traffic on a narrow address set so stages collide often.
        for (int n = 0; n < 400; n++) begin
            logic st;
            rst    = ($urandom_range(0, 39) == 0);
            re1    = 1'($urandom); raddr1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            re2    = 1'($urandom); raddr2 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ex_ld  = 1'($urandom); ex_we = 1'($urandom); ex_wa = 5'($urandom_range(0, 7)); ex_wd = $urandom;
            mem_we = 1'($urandom); mem_wa = 5'($urandom_range(0, 7)); mem_wd = $urandom;
            wb_we  = ($urandom_range(0, 3) != 0);
            wb_wa  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            wb_wd  = $urandom;
            #1;
            st = model_stall();
            check("rnd_stall", {31'h0, stallreq_ld}, {31'h0, st});
            if (st == NO_STOP) begin
                check("rnd_rdata1", rdata1, model_read(re1, raddr1));
                check("rnd_rdata2", rdata2, model_read(re2, raddr2));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
